// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_divider.
// SEQ_DIVIDER_ABORT_EN adds the abort request line.
interface seq_divider_if #(
  parameter int size = 32
);
  logic            start;
`ifdef SEQ_DIVIDER_ABORT_EN
  logic            abort;
`endif
  logic [size-1:0] dividend;
  logic [size-1:0] divisor;
  logic            busy;
  logic            done;
  logic [size-1:0] quotient;
  logic [size-1:0] remainder;
  logic            div_by_zero;

`ifdef SEQ_DIVIDER_ABORT_EN
  modport master (
    output start, abort, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, abort, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a
// single size+1-bit subtract stage. SEQ_DIVIDER_ABORT_EN enables RUN abort.
module seq_divider #(
  parameter int size = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(size + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [size-1:0] q_r;
  logic [size:0]   r_r;
  logic [size-1:0] divisor_r;
  logic [CW-1:0]   cnt_r;
  logic            busy_r;
  logic            done_r;
  logic            dbz_r;
  logic [size-1:0] quotient_r;
  logic [size-1:0] remainder_r;

  logic [size:0]   rs_s;
  logic [size:0]   diff_s;
  logic [size:0]   r_next_s;
  logic [size-1:0] q_next_s;
  logic            borrow_s;
  logic            last_s;
  logic            zero_div_s;
  logic            abort_s;

`ifdef SEQ_DIVIDER_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  assign zero_div_s = (bus.divisor == {size{1'b0}});

  // Shared shift/subtract/restore stage for one iteration.
  always_comb begin
    rs_s     = {r_r[size-1:0], q_r[size-1]};
    diff_s   = rs_s - {1'b0, divisor_r};
    borrow_s = diff_s[size];
    if (borrow_s) begin
      r_next_s = rs_s;
    end else begin
      r_next_s = diff_s;
    end
    q_next_s = {q_r[size-2:0], ~borrow_s};
    last_s   = (cnt_r == CW'(1'b1));
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (zero_div_s) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (abort_s) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r         <= {size{1'b0}};
      r_r         <= {(size+1){1'b0}};
      divisor_r   <= {size{1'b0}};
      cnt_r       <= {CW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= {size{1'b0}};
      remainder_r <= {size{1'b0}};
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (zero_div_s) begin
              quotient_r  <= {size{1'b1}};
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end else begin
              q_r       <= bus.dividend;
              r_r       <= {(size+1){1'b0}};
              divisor_r <= bus.divisor;
              cnt_r     <= CW'(size);
              dbz_r     <= 1'b0;
            end
          end
        end
        RUN: begin
          // Results are published only on the final iteration so they stay stable between dones.
          if (!abort_s) begin
            q_r   <= q_next_s;
            r_r   <= r_next_s;
            cnt_r <= cnt_r - CW'(1'b1);
            if (last_s) begin
              quotient_r  <= q_next_s;
              remainder_r <= r_next_s[size-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider with a scoreboard of expected results.
module tb_seq_divider;
  localparam int SZ = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_dbz;

  seq_divider_if #(.size(SZ)) bus ();

  seq_divider #(.size(SZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Drives start for one cycle from a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) push_exp(a, b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk("done_timeout", 64'(bus.done), 64'd1);
  endtask

  task automatic count_dones(input int cycles, output int c);
    c = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) c++;
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_q"}, 64'(bus.quotient), 64'(e.q));
      chk({tag, "_r"}, 64'(bus.remainder), 64'(e.r));
      chk({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
      if (!e.dbz) begin
        chk({tag, "_inv_sum"}, 64'(bus.quotient) * 64'(e.b) + 64'(bus.remainder), 64'(e.a));
        chk({tag, "_inv_rem"}, 64'(bus.remainder < e.b), 64'd1);
      end
      last_q   = e.q;
      last_r   = e.r;
      last_dbz = e.dbz;
    end
  endtask

  task automatic full_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n;
    launch(a, b, 1'b1);
    chk({tag, "_busy_c1"}, 64'(bus.busy), 64'd1);
    wait_done(60, n);
    chk({tag, "_latency"}, 64'(n + 1), (b == 32'd0) ? 64'd1 : 64'd33);
    if (bus.done === 1'b1) begin
      chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
      check_result(tag);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    chk({tag, "_q_hold"}, 64'(bus.quotient), 64'(last_q));
  endtask

  initial begin
    int n;
    int c;
    int nrand;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;
`ifdef SEQ_DIVIDER_ABORT_EN
    bus.abort    = 1'b0;
    nrand        = 1000;
`else
    nrand        = 40;
`endif
    last_q = 32'd0;
    last_r = 32'd0;
    last_dbz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_q", 64'(bus.quotient), 64'd0);
    chk("rst_r", 64'(bus.remainder), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    full_op(32'd100, 32'd7, "d100_7");
    full_op(32'd5, 32'd9, "d5_9");
    full_op(32'hFFFF_FFFF, 32'd1, "dmax_1");
    full_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dmax_max");
    full_op(32'h1234, 32'd0, "dzero");
    full_op(32'd100, 32'd7, "dbz_clear");

    // Second request during RUN is dropped.
    launch(32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    chk("ign_q_stable", 64'(bus.quotient), 64'(last_q));
    bus.start    = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40, n);
    chk("ign_latency", 64'(n + 11), 64'd33);
    if (bus.done === 1'b1) check_result("ign");
    count_dones(40, c);
    chk("ign_no_second_done", 64'(c), 64'd0);

    // start held high: next op accepted in the IDLE cycle after DONE.
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    push_exp(32'd100, 32'd7);
    @(negedge clk);
    bus.dividend = 32'd81;
    bus.divisor  = 32'd9;
    wait_done(60, n);
    chk("b2b_lat1", 64'(n + 1), 64'd33);
    if (bus.done === 1'b1) check_result("b2b1");
    push_exp(32'd81, 32'd9);
    @(negedge clk);
    chk("b2b_idle_gap", 64'(bus.busy), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy2", 64'(bus.busy), 64'd1);
    wait_done(60, n);
    chk("b2b_lat2", 64'(n), 64'd32);
    if (bus.done === 1'b1) check_result("b2b2");
    @(negedge clk);

    // Asynchronous reset mid-operation.
    launch(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_q", 64'(bus.quotient), 64'd0);
    chk("arst_r", 64'(bus.remainder), 64'd0);
    chk("arst_dbz", 64'(bus.div_by_zero), 64'd0);
    last_q = 32'd0;
    last_r = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(40, c);
    chk("arst_no_done", 64'(c), 64'd0);
    full_op(32'd81, 32'd9, "post_rst");

`ifdef SEQ_DIVIDER_ABORT_EN
    launch(32'd100, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_q", 64'(bus.quotient), 64'd9);
    chk("abort_r", 64'(bus.remainder), 64'd0);
    chk("abort_dbz", 64'(bus.div_by_zero), 64'd0);
    count_dones(40, c);
    chk("abort_no_done", 64'(c), 64'd0);
`endif

    for (int i = 0; i < nrand; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb = $urandom_range(255, 1);
      if (i % 4 == 1) rb = rb >> $urandom_range(31, 0);
      if (i % 16 == 2) rb = 32'd0;
      full_op(ra, rb, "rnd");
    end

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
